// File: rtl/fifo_write_arbiter.sv
// Packet-level round-robin arbiter feeding one shared FIFO write port.
// A granted requester owns the port until its tail flit is accepted.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((NUM_REQ & (NUM_REQ - 1)) != 0)) begin : g_bad_num_req
    $error("fifo_write_arbiter: NUM_REQ must be a power of two in 2..8");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]    pkt_count_q, pkt_count_d;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        cand;
  logic [PTR_W-1:0]        owner_idx;
  logic [DATA_WIDTH-1:0]   din_sel;
  logic                    tail_xfer;

  // Pointer arithmetic wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + PTR_W'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    din_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = PTR_W'(i);
        din_sel   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    busy       = (state_q == LOCKED);
    req_ready  = busy ? (grant_q & {NUM_REQ{~fifo_full}}) : '0;
    fifo_wr_en = req_valid[owner_idx] & req_ready[owner_idx];
    fifo_din   = busy ? din_sel : '0;
    tail_xfer  = fifo_wr_en & req_last[owner_idx];
    grant      = grant_q;
    pkt_count  = pkt_count_q;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          state_d     = IDLE;
          grant_d     = '0;
          rr_ptr_d    = owner_idx + PTR_W'(1);
          pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: default instance plus a 4-bit counter instance.
module tb_fifo_write_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic         fifo_full;

  logic [3:0]   req_ready, req_ready4;
  logic         fifo_wr_en, fifo_wr_en4;
  logic [31:0]  fifo_din, fifo_din4;
  logic [3:0]   grant, grant4;
  logic         busy, busy4;
  logic [15:0]  pkt_count;
  logic [3:0]   pkt_count4;

  int n_asserts;
  int n_fail;
  int wr_cnt;
  int w0;
  logic [31:0] last_wr;

  fifo_write_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant(grant),
    .busy(busy), .pkt_count(pkt_count)
  );

  fifo_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready4), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en4), .fifo_din(fifo_din4), .grant(grant4),
    .busy(busy4), .pkt_count(pkt_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writes are committed at the next rising edge; inputs only change just after rising edges.
  initial begin
    wr_cnt  = 0;
    last_wr = '0;
  end
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      last_wr = fifo_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic b,
                           input logic [3:0] r, input logic w, input logic [31:0] d);
    #1;
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"},  32'(busy), 32'(b));
    chk({tag, "_ready"}, 32'(req_ready), 32'(r));
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'(w));
    chk({tag, "_din"},   fifo_din, d);
    chk({tag, "_grant_c4"}, 32'(grant4), 32'(g));
    chk({tag, "_busy_c4"},  32'(busy4), 32'(b));
    chk({tag, "_ready_c4"}, 32'(req_ready4), 32'(r));
    chk({tag, "_wr_en_c4"}, 32'(fifo_wr_en4), 32'(w));
    chk({tag, "_din_c4"},   fifo_din4, d);
  endtask

  task automatic chk_pkt(input string tag, input int exp);
    chk(tag, 32'(pkt_count), 32'(exp));
    chk({tag, "_c4"}, 32'(pkt_count4), 32'(exp & 15));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    #1;
    chk_state("reset", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("reset_cnt", 0);
    #20;
    rst = 1'b0;

    // Requesters 0 and 2 contend with 3-flit packets; 0 then queues a 1-flit packet.
    req_valid = 4'b0101;
    set_data(0, 32'hA0);
    set_data(2, 32'hC0);
    tick(); chk_state("s1_a0", 4'b0001, 1, 4'b0001, 1, 32'hA0);
    tick(); set_data(0, 32'hA1); chk_state("s1_a1", 4'b0001, 1, 4'b0001, 1, 32'hA1);
    tick(); set_data(0, 32'hA2); req_last[0] = 1'b1;
    chk_state("s1_a2", 4'b0001, 1, 4'b0001, 1, 32'hA2);
    tick(); set_data(0, 32'hB0);
    chk_state("s1_gap", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s1_cnt1", 1);
    tick(); chk_state("s1_c0", 4'b0100, 1, 4'b0100, 1, 32'hC0);
    tick(); set_data(2, 32'hC1); chk_state("s1_c1", 4'b0100, 1, 4'b0100, 1, 32'hC1);
    tick(); set_data(2, 32'hC2); req_last[2] = 1'b1;
    chk_state("s1_c2", 4'b0100, 1, 4'b0100, 1, 32'hC2);
    tick(); req_valid[2] = 1'b0; req_last[2] = 1'b0;
    chk_state("s1_gap2", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s1_cnt2", 2);
    tick(); chk_state("s1_b0", 4'b0001, 1, 4'b0001, 1, 32'hB0);
    tick(); req_valid[0] = 1'b0; req_last[0] = 1'b0;
    chk_state("s1_gap3", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s1_cnt3", 3);
    tick(); chk_state("s1_hold", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk("s1_wr_cnt", 32'(wr_cnt), 32'd7);
    chk("s1_last_wr", last_wr, 32'hB0);

    // All four stream single-flit packets from a fresh reset.
    rst = 1'b1;
    #1; chk_pkt("s2_rst_cnt", 0);
    #3; rst = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 32'h10 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_state("s2_grant", 4'(1 << (k % 4)), 1, 4'(1 << (k % 4)), 1, 32'h10 + 32'(k % 4));
      tick();
      chk_state("s2_idle", 4'b0000, 0, 4'b0000, 0, 32'h0);
      chk_pkt("s2_cnt", k + 1);
    end
    req_valid = '0;
    req_last  = '0;

    // Owner 1 back-pressured for 5 cycles while 0 and 3 wait.
    req_valid = 4'b1011;
    set_data(1, 32'h100);
    set_data(3, 32'h300);
    set_data(0, 32'hAA);
    req_last[0] = 1'b1;
    w0 = wr_cnt;
    tick(); chk_state("s3_start", 4'b0010, 1, 4'b0010, 1, 32'h100);
    tick(); set_data(1, 32'h101); fifo_full = 1'b1;
    chk_state("s3_full", 4'b0010, 1, 4'b0000, 0, 32'h101);
    repeat (4) begin
      tick(); chk_state("s3_full", 4'b0010, 1, 4'b0000, 0, 32'h101);
    end
    tick(); fifo_full = 1'b0;
    chk_state("s3_resume", 4'b0010, 1, 4'b0010, 1, 32'h101);
    tick(); set_data(1, 32'h102); req_last[1] = 1'b1;
    chk_state("s3_tail", 4'b0010, 1, 4'b0010, 1, 32'h102);
    tick(); req_valid[1] = 1'b0; req_last[1] = 1'b0;
    chk_state("s3_done", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s3_cnt", 6);
    chk("s3_writes", 32'(wr_cnt - w0), 32'd3);
    chk("s3_last_wr", last_wr, 32'h102);

    // Owner 3 stalls its own packet for 2 cycles while 0 waits.
    tick(); chk_state("s4_start", 4'b1000, 1, 4'b1000, 1, 32'h300);
    tick(); req_valid[3] = 1'b0;
    chk_state("s4_stall", 4'b1000, 1, 4'b1000, 0, 32'h300);
    tick(); chk_state("s4_stall2", 4'b1000, 1, 4'b1000, 0, 32'h300);
    tick(); req_valid[3] = 1'b1; set_data(3, 32'h301); req_last[3] = 1'b1;
    chk_state("s4_tail", 4'b1000, 1, 4'b1000, 1, 32'h301);
    tick(); req_valid[3] = 1'b0; req_last[3] = 1'b0;
    chk_state("s4_done", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s4_cnt", 7);
    tick(); chk_state("s4_next", 4'b0001, 1, 4'b0001, 1, 32'hAA);
    tick(); req_valid[0] = 1'b0; req_last[0] = 1'b0;
    chk_state("s4_done2", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s4_cnt2", 8);

    // Move the pointer to 2, then reset asynchronously inside requester 2's packet.
    req_valid[1] = 1'b1; req_last[1] = 1'b1; set_data(1, 32'h111);
    tick(); chk_state("s5_pre", 4'b0010, 1, 4'b0010, 1, 32'h111);
    tick(); req_valid[1] = 1'b0; req_last[1] = 1'b0;
    chk_state("s5_pre_done", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s5_pre_cnt", 9);
    req_valid[2] = 1'b1; set_data(2, 32'h200);
    tick(); chk_state("s5_lock", 4'b0100, 1, 4'b0100, 1, 32'h200);
    #1; rst = 1'b1;
    chk_state("s5_rst", 4'b0000, 0, 4'b0000, 0, 32'h0);
    chk_pkt("s5_rst_cnt", 0);
    tick(); #1; rst = 1'b0;
    req_valid = 4'b0110;
    chk_state("s5_released", 4'b0000, 0, 4'b0000, 0, 32'h0);
    tick(); chk_state("s5_restart", 4'b0010, 1, 4'b0010, 1, 32'h111);

    // Counter wrap on the 4-bit instance.
    req_valid = '0;
    rst = 1'b1;
    #2; rst = 1'b0;
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    set_data(0, 32'h5A);
    for (int k = 1; k <= 17; k++) begin
      tick();
      tick();
      if (k == 15) chk("s6_c4_15", 32'(pkt_count4), 32'd15);
      if (k == 16) begin
        chk("s6_c4_16", 32'(pkt_count4), 32'd0);
        chk("s6_c16_16", 32'(pkt_count), 32'd16);
      end
      if (k == 17) begin
        chk("s6_c4_17", 32'(pkt_count4), 32'd1);
        chk("s6_c16_17", 32'(pkt_count), 32'd17);
      end
    end
    req_valid = '0;
    req_last  = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, the flit width; it SHALL equal the shared FIFO's data width.
REQ-002 Parameter NUM_REQ, default 4, the number of requesters; it SHALL be a power of two, 2..8.
REQ-003 Parameter CNT_WIDTH, default 16, the width of the packet counter.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester flit valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-requester flit; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  per-requester tail-flit marker.
REQ-009 req_ready  output  NUM_REQ  per-requester flit accept.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 fifo_wr_en  output  1  write strobe to the shared FIFO.
REQ-012 fifo_din  output  DATA_WIDTH  write data to the shared FIFO.
REQ-013 grant  output  NUM_REQ  one-hot current owner; all zeros when no packet is locked.
REQ-014 busy  output  1  high while a packet is locked.
REQ-015 pkt_count  output  CNT_WIDTH  number of completed packets, wrapping modulo 2^CNT_WIDTH.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and LOCKED.
REQ-017 In IDLE with any req_valid set, the block SHALL, at the next edge, select a winner by round-robin starting at index rr_ptr, then load grant and enter LOCKED; one cycle of arbitration latency.
REQ-018 Round-robin order SHALL be rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first index with req_valid set wins.
REQ-019 In IDLE with no req_valid set, the state SHALL remain IDLE, grant SHALL stay 0, and rr_ptr SHALL stay unchanged.
REQ-020 In LOCKED, req_ready[g] SHALL equal ~fifo_full combinationally for the owner g, and SHALL be 0 for all other requesters.
REQ-021 In IDLE, req_ready SHALL be all zeros and fifo_wr_en SHALL be 0.
REQ-022 fifo_wr_en SHALL equal req_valid[g] & req_ready[g], combinationally.
REQ-023 fifo_din SHALL equal req_data of requester g whenever busy is high, and 0 otherwise.
REQ-024 A transfer occurs in any cycle with fifo_wr_en high; no flit SHALL be written while fifo_full is high.
REQ-025 A transfer with req_last[g] high SHALL, at that edge, return the FSM to IDLE, clear grant, set rr_ptr to (g+1) mod NUM_REQ, and increment pkt_count.
REQ-026 While LOCKED, the grant SHALL NOT change regardless of other requesters' valid signals; packets are never interleaved.
REQ-027 Owner req_valid low while LOCKED SHALL stall the packet without releasing the lock.
REQ-028 A single-flit packet (last on the first flit) SHALL occupy exactly one LOCKED cycle when fifo_full is low.
REQ-029 The next packet SHALL NOT be granted in the same cycle as the tail transfer; there is a minimum of one IDLE cycle between packets.
REQ-030 pkt_count at its maximum value SHALL wrap to 0 on the next completion.

Reset
REQ-031 Assertion of rst SHALL immediately force state IDLE, grant 0, busy 0, rr_ptr 0, and pkt_count 0; req_ready and fifo_wr_en SHALL therefore go to 0 without waiting for a clock edge.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from index 0.
REQ-033 The block SHALL hold no other state; no requester data is stored internally.

Verification
REQ-034 Scenario: requesters 0 and 2 both present a 3-flit packet from reset, with fifo_full low -> grant=0001 one cycle later; 3 writes on consecutive cycles; 1 IDLE cycle; then grant=0100 and 3 writes; pkt_count=2.
REQ-035 Scenario: all 4 requesters stream single-flit packets continuously -> grant order 0,1,2,3,0 with every grant separated by an IDLE cycle; pkt_count increments by 1 per 2 cycles.
REQ-036 Scenario: owner 1 is mid-packet, then fifo_full is held high for 5 cycles -> req_ready[1]=0 and fifo_wr_en=0 for those 5 cycles; grant stays 0010; the packet resumes with no flit lost or duplicated.
REQ-037 Scenario: owner 3 drops req_valid for 2 cycles mid-packet while requester 0 is valid -> grant stays 1000 and busy stays 1; after 3's tail flit, grant moves to 0001.
REQ-038 Scenario: rst is pulsed asynchronously (between clock edges) mid-packet of requester 2 -> grant, busy and fifo_wr_en drop immediately; after release with requesters 1 and 2 valid, grant=0010.
REQ-039 Scenario: with CNT_WIDTH=4, complete 17 packets -> pkt_count reads 15 after 15 packets, 0 after 16, and 1 after 17.
